// File: rtl/fifo_mc_rr.sv
// -----------------------------------------------------------------------------
// fifo_mc_rr
// Multi-channel synchronous FIFO. NUM_CH independent input queues share one
// output port. A round-robin arbiter merges them onto that port. Each queue
// has its own ready/valid handshake, occupancy report and synchronous flush.
// An optional fall-through path lets an empty queue forward its input
// combinationally.
//
// Optional feature macro: FIFO_MC_RR_WATERMARK_EN
//   When defined, it adds the AF_THRESH/AE_THRESH parameters and the
//   almost_full_o/almost_empty_o ports.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   flush_i         [NUM_CH]             per-channel synchronous flush
//   in_valid_i      [NUM_CH]             per-channel push request
//   in_ready_o      [NUM_CH]             channel can accept data
//   in_data_i       [NUM_CH*DATA_WIDTH]  per-channel payload, channel c at c*DATA_WIDTH
//   out_valid_o                          out_data_o is valid
//   out_ready_i                          consumer accepts
//   out_data_o      [DATA_WIDTH]         head of the granted channel
//   out_ch_o        [CH_W]               index of the granted channel
//   usage_o         [NUM_CH*CNT_W]       per-channel occupancy, 0..DEPTH
//   almost_full_o   [NUM_CH]             count >= AF_THRESH (macro only)
//   almost_empty_o  [NUM_CH]             count <= AE_THRESH (macro only)
// -----------------------------------------------------------------------------
module fifo_mc_rr #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter bit          FALL_THROUGH = 1'b0,
`ifdef FIFO_MC_RR_WATERMARK_EN
   parameter int unsigned AF_THRESH    = DEPTH - 1,
   parameter int unsigned AE_THRESH    = 1,
`endif
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_CH-1:0]            flush_i,
   input  logic [NUM_CH-1:0]            in_valid_i,
   output logic [NUM_CH-1:0]            in_ready_o,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [DATA_WIDTH-1:0]        out_data_o,
   output logic [CH_W-1:0]              out_ch_o,
`ifdef FIFO_MC_RR_WATERMARK_EN
   output logic [NUM_CH-1:0]            almost_full_o,
   output logic [NUM_CH-1:0]            almost_empty_o,
`endif
   output logic [NUM_CH*CNT_W-1:0]      usage_o
);

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
   logic [DATA_WIDTH-1:0] in_data  [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr_d [NUM_CH];
   logic [PTR_W-1:0]      wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0]      wr_ptr_d [NUM_CH];
   logic [CNT_W-1:0]      cnt_q    [NUM_CH];
   logic [CNT_W-1:0]      cnt_d    [NUM_CH];
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       grant;
   logic [NUM_CH-1:0]     req, push, pop, ft_pop, wr_en;
   logic                  any_req;
   logic                  found;
   logic [CH_W-1:0]       idx_w;
   int                    idx;

   // Request and ready generation per channel; neither looks at out_ready_i.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         in_data[c]    = in_data_i[c*DATA_WIDTH +: DATA_WIDTH];
         in_ready_o[c] = (cnt_q[c] < CNT_W'(DEPTH)) & ~flush_i[c];
         req[c]        = (cnt_q[c] != '0) & ~flush_i[c];
         if (FALL_THROUGH)
            req[c] = req[c] | ((cnt_q[c] == '0) & in_valid_i[c] & ~flush_i[c]);
      end
   end

   // Round-robin scan starting at rr_ptr_q, modulo NUM_CH.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
         idx_w = CH_W'(idx);
         if (!found && req[idx_w]) begin
            grant = idx_w;
            found = 1'b1;
         end
      end
   end

   assign any_req     = |req;
   assign out_valid_o = any_req;
   assign out_ch_o    = grant;

   // A grant on an empty channel can only be a fall-through grant.
   always_comb begin
      out_data_o = mem_q[grant][rd_ptr_q[grant]];
      if (FALL_THROUGH && (cnt_q[grant] == '0))
         out_data_o = in_data[grant];
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         push[c]   = in_valid_i[c] & in_ready_o[c];
         pop[c]    = any_req & out_ready_i & (grant == CH_W'(c));
         // A fall-through pop consumes the input word directly: no write,
         // no pointer or count change.
         ft_pop[c] = FALL_THROUGH & pop[c] & (cnt_q[c] == '0);
         wr_en[c]  = push[c] & ~ft_pop[c];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_req && out_ready_i)
         rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         rd_ptr_d[c] = rd_ptr_q[c];
         wr_ptr_d[c] = wr_ptr_q[c];
         cnt_d[c]    = cnt_q[c];
         if (flush_i[c]) begin
            rd_ptr_d[c] = '0;
            wr_ptr_d[c] = '0;
            cnt_d[c]    = '0;
         end else if (!ft_pop[c]) begin
            if (push[c]) wr_ptr_d[c] = next_ptr(wr_ptr_q[c]);
            if (pop[c])  rd_ptr_d[c] = next_ptr(rd_ptr_q[c]);
            if (push[c] && !pop[c])
               cnt_d[c] = cnt_q[c] + 1'b1;
            else if (pop[c] && !push[c])
               cnt_d[c] = cnt_q[c] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int c = 0; c < NUM_CH; c++) begin
            rd_ptr_q[c] <= rd_ptr_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            cnt_q[c]    <= cnt_d[c];
         end
      end
   end

   // Storage carries no reset; only valid entries are ever read out.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= in_data[c];
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++)
         usage_o[c*CNT_W +: CNT_W] = cnt_q[c];
   end

`ifdef FIFO_MC_RR_WATERMARK_EN
   if ((AF_THRESH > DEPTH) || (AE_THRESH >= DEPTH)) begin : g_thresh_err
      $error("fifo_mc_rr: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         almost_full_o[c]  = (cnt_q[c] >= CNT_W'(AF_THRESH));
         almost_empty_o[c] = (cnt_q[c] <= CNT_W'(AE_THRESH));
      end
   end
`endif

endmodule

// File: tb/tb_fifo_mc_rr.sv
module tb_fifo_mc_rr;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int DP  = 5;
   localparam int CW  = 3;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;

   logic [NCH-1:0]    flush = '0, in_valid = '0, in_ready;
   logic [NCH*DW-1:0] in_data = '0;
   logic              out_valid, out_ready = 1'b0;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_ch;
   logic [NCH*CW-1:0] usage;

   logic [NCH-1:0]    flush_ft = '0, in_valid_ft = '0, in_ready_ft;
   logic [NCH*DW-1:0] in_data_ft = '0;
   logic              out_valid_ft, out_ready_ft = 1'b0;
   logic [DW-1:0]     out_data_ft;
   logic [1:0]        out_ch_ft;
   logic [NCH*CW-1:0] usage_ft;

`ifdef FIFO_MC_RR_WATERMARK_EN
   logic [NCH-1:0] af, ae, af_ft, ae_ft;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_mc_rr #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DP), .FALL_THROUGH(1'b0)
`ifdef FIFO_MC_RR_WATERMARK_EN
      , .AF_THRESH(4), .AE_THRESH(1)
`endif
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_data_o(out_data), .out_ch_o(out_ch),
`ifdef FIFO_MC_RR_WATERMARK_EN
      .almost_full_o(af), .almost_empty_o(ae),
`endif
      .usage_o(usage)
   );

   fifo_mc_rr #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DP), .FALL_THROUGH(1'b1)
`ifdef FIFO_MC_RR_WATERMARK_EN
      , .AF_THRESH(4), .AE_THRESH(1)
`endif
   ) dut_ft (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_ft), .in_valid_i(in_valid_ft),
      .in_ready_o(in_ready_ft), .in_data_i(in_data_ft), .out_valid_o(out_valid_ft),
      .out_ready_i(out_ready_ft), .out_data_o(out_data_ft), .out_ch_o(out_ch_ft),
`ifdef FIFO_MC_RR_WATERMARK_EN
      .almost_full_o(af_ft), .almost_empty_o(ae_ft),
`endif
      .usage_o(usage_ft)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] u_of(input logic [NCH*CW-1:0] u, input int c);
      return 32'(u[c*CW +: CW]);
   endfunction

   task automatic set_d(input int c, input logic [DW-1:0] d);
      in_data[c*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni    = 1'b0;
      in_valid  = '0;
      flush     = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      tick();
   endtask

   logic [1:0]    exp_ch [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
   logic [DW-1:0] exp_dt [6] = '{8'h00, 8'h10, 8'h30, 8'h01, 8'h11, 8'h31};

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'hF);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_ch", 32'(out_ch), 32'h0);
      chk("rst_usage", 32'(usage), 32'h0);
      chk("rst_ft_out_valid", 32'(out_valid_ft), 32'h0);
`ifdef FIFO_MC_RR_WATERMARK_EN
      chk("rst_af", 32'(af), 32'h0);
      chk("rst_ae", 32'(ae), 32'hF);
`endif
      @(negedge clk);
      rst_ni = 1'b1;
      tick();

      // Fill ch2 to DEPTH with the consumer stalled
      out_ready   = 1'b0;
      in_valid[2] = 1'b1;
      set_d(2, 8'h20);
      #1;
      chk("no_bypass_without_ft", 32'(out_valid), 32'h0);
      for (int k = 0; k < DP; k++) begin
         set_d(2, 8'h20 + 8'(k));
         #1;
         chk("fill_in_ready", 32'(in_ready[2]), 32'h1);
         tick();
      end
      in_valid[2] = 1'b0;
      #1;
      chk("full_usage2", u_of(usage, 2), 32'd5);
      chk("full_in_ready2", 32'(in_ready[2]), 32'h0);
      chk("full_out_ch", 32'(out_ch), 32'd2);
      out_ready = 1'b1;
      for (int k = 0; k < DP; k++) begin
         #1;
         chk("drain_valid", 32'(out_valid), 32'h1);
         chk("drain_ch", 32'(out_ch), 32'd2);
         chk("drain_data", 32'(out_data), 32'h20 + 32'(k));
         tick();
      end
      #1;
      chk("drained_usage2", u_of(usage, 2), 32'd0);
      chk("drained_valid", 32'(out_valid), 32'h0);

      // Round-robin fairness from reset across ch0, ch1, ch3
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = 4'b1011;
         set_d(0, 8'h00 + 8'(k));
         set_d(1, 8'h10 + 8'(k));
         set_d(3, 8'h30 + 8'(k));
         tick();
      end
      in_valid = '0;
      #1;
      chk("rr_usage", 32'(usage), {20'd0, 3'd3, 3'd0, 3'd3, 3'd3});
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_grant", 32'(out_ch), 32'(exp_ch[i]));
         chk("rr_data", 32'(out_data), 32'(exp_dt[i]));
         tick();
      end
      out_ready = 1'b0;

      // Simultaneous push and pop on ch1 at count 2 (pointers wrap at 4)
      do_reset();
      in_valid[1] = 1'b1;
      set_d(1, 8'h40);
      tick();
      set_d(1, 8'h41);
      tick();
      for (int i = 0; i < 10; i++) begin
         set_d(1, 8'h42 + 8'(i));
         out_ready = 1'b1;
         #1;
         chk("pp_usage1", u_of(usage, 1), 32'd2);
         chk("pp_ch", 32'(out_ch), 32'd1);
         chk("pp_data", 32'(out_data), 32'h40 + 32'(i));
         tick();
      end
      in_valid  = '0;
      out_ready = 1'b0;
      #1;
      chk("pp_end_usage1", u_of(usage, 1), 32'd2);
      chk("pp_end_data", 32'(out_data), 32'h4A);
      out_ready = 1'b1;
      tick();
      #1;
      chk("pp_end_data2", 32'(out_data), 32'h4B);
      out_ready = 1'b0;

      // Flush ch0 while pushing on it; ch1 untouched
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = (k < 2) ? 4'b0011 : 4'b0001;
         set_d(0, 8'h50 + 8'(k));
         set_d(1, 8'h60 + 8'(k));
         tick();
      end
      in_valid = 4'b0001;
      set_d(0, 8'h5F);
      flush = 4'b0001;
      #1;
      chk("flush_in_ready0", 32'(in_ready[0]), 32'h0);
      chk("flush_in_ready1", 32'(in_ready[1]), 32'h1);
      chk("flush_grant", 32'(out_ch), 32'd1);
      tick();
      flush    = '0;
      in_valid = '0;
      #1;
      chk("flush_usage0", u_of(usage, 0), 32'd0);
      chk("flush_usage1", u_of(usage, 1), 32'd2);
      out_ready = 1'b1;
      #1;
      chk("flush_ch1_data0", 32'(out_data), 32'h60);
      tick();
      #1;
      chk("flush_ch1_data1", 32'(out_data), 32'h61);
      chk("flush_ch1_ch", 32'(out_ch), 32'd1);
      tick();
      out_ready = 1'b0;
      #1;
      chk("flush_idle", 32'(out_valid), 32'h0);
      in_valid[0] = 1'b1;
      set_d(0, 8'h70);
      tick();
      in_valid = '0;
      #1;
      chk("post_flush_ch", 32'(out_ch), 32'd0);
      chk("post_flush_data", 32'(out_data), 32'h70);
      chk("post_flush_usage0", u_of(usage, 0), 32'd1);

      // Fall-through instance
      in_valid_ft = 4'b1000;
      in_data_ft[3*DW +: DW] = 8'hA5;
      out_ready_ft = 1'b1;
      #1;
      chk("ft_valid", 32'(out_valid_ft), 32'h1);
      chk("ft_data", 32'(out_data_ft), 32'hA5);
      chk("ft_ch", 32'(out_ch_ft), 32'd3);
      tick();
      in_valid_ft = '0;
      #1;
      chk("ft_usage3", u_of(usage_ft, 3), 32'd0);
      chk("ft_idle", 32'(out_valid_ft), 32'h0);
      out_ready_ft = 1'b0;
      in_valid_ft  = 4'b1000;
      #1;
      chk("ft_stall_valid", 32'(out_valid_ft), 32'h1);
      tick();
      in_valid_ft = '0;
      #1;
      chk("ft_stall_usage3", u_of(usage_ft, 3), 32'd1);
      chk("ft_stored_data", 32'(out_data_ft), 32'hA5);
      chk("ft_stored_ch", 32'(out_ch_ft), 32'd3);
      out_ready_ft = 1'b1;
      tick();
      #1;
      chk("ft_popped_usage3", u_of(usage_ft, 3), 32'd0);
      out_ready_ft = 1'b0;

      // Watermarks and reset mid-burst
      do_reset();
      in_valid[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_d(0, 8'h80 + 8'(k));
         tick();
`ifdef FIFO_MC_RR_WATERMARK_EN
         if (k == 2) chk("af_below", 32'(af[0]), 32'h0);
`endif
      end
      in_valid = '0;
      #1;
      chk("wm_usage0", u_of(usage, 0), 32'd4);
`ifdef FIFO_MC_RR_WATERMARK_EN
      chk("wm_af0", 32'(af[0]), 32'h1);
      chk("wm_ae0", 32'(ae[0]), 32'h0);
`endif
      in_valid = 4'b0011;
      set_d(0, 8'h84);
      set_d(1, 8'h90);
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst_usage", 32'(usage), 32'h0);
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_in_ready", 32'(in_ready), 32'hF);
`ifdef FIFO_MC_RR_WATERMARK_EN
      chk("midrst_ae", 32'(ae), 32'hF);
      chk("midrst_af", 32'(af), 32'h0);
`endif
      in_valid = '0;
      @(negedge clk);
      rst_ni = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
